dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory (9-bit address, XLEN data, 1-cycle read latency, registered address) between two requesters.
- Requester 0 is the core MEM stage. Requester 1 is an auxiliary master (IO/debug loader).
- The core has fixed priority. A starvation counter forces an aux grant after STARVE_LIMIT lost cycles, and the core is stalled for that cycle.
- Sits between the MEM stage, the aux master and data_memory. Its stall output is ORed into the pipeline stall.

Parameters:
XLEN, 32, data width
ADDR_W, 9, memory word address width
STARVE_LIMIT, 4, consecutive lost aux cycles before aux is forced to win (valid range 1..15)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
core_req  in  1  core access request (level, per cycle)
core_we  in  1  core write (1) / read (0)
core_addr  in  ADDR_W  core address
core_wdata  in  XLEN  core write data
core_gnt  out  1  core access accepted this cycle
core_stall  out  1  core_req & ~core_gnt
core_rvalid  out  1  core read data valid
core_rdata  out  XLEN  core read data
aux_req  in  1  aux access request
aux_we  in  1  aux write/read
aux_addr  in  ADDR_W  aux address
aux_wdata  in  XLEN  aux write data
aux_gnt  out  1  aux access accepted this cycle
aux_rvalid  out  1  aux read data valid
aux_rdata  out  XLEN  aux read data
mem_address  out  ADDR_W  to data_memory address
mem_data  out  XLEN  to data_memory data
mem_wren  out  1  to data_memory wren
mem_q  in  XLEN  from data_memory q
starve_cnt  out  4  current starvation count (debug/verification)

Behaviour:
- Reset (reset=0, async): starve_cnt=0, rd_owner=NONE, core_rvalid=aux_rvalid=0. All grants and mem_wren are combinationally 0 while reset is low.
- Arbitration is combinational within the cycle. A transfer happens on the rising edge where req&gnt=1.
- Winner rules:
  - Only core_req: core wins.
  - Only aux_req: aux wins.
  - Both requesting, starve_cnt<STARVE_LIMIT: core wins.
  - Both requesting, starve_cnt==STARVE_LIMIT: aux wins (forced).
  - Neither requesting: no grant.
- Exactly one gnt high at most; never a grant without req.
- Memory mux:
  - mem_address/mem_data/mem_wren come from the winner; mem_wren = winner_we & grant.
  - No winner: mem_address=0, mem_data=0, mem_wren=0.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each edge with aux_req & ~aux_gnt.
  - Cleared to 0 on aux grant, or on any edge where aux_req=0.
  - Holds when STARVE_LIMIT is reached until aux is granted.
- Read return, 1-cycle latency:
  - On a granted read edge, rd_owner <= CORE or AUX; otherwise rd_owner <= NONE.
  - core_rvalid = (rd_owner==CORE); aux_rvalid = (rd_owner==AUX); each is a 1-cycle pulse per read.
  - core_rdata and aux_rdata = mem_q unconditionally. Data is qualified only by rvalid.
- Granted writes produce no rvalid.
- Back-to-back:
  - Reads from alternating owners on consecutive cycles each get their own rvalid in order.
  - A write followed by a read of the same address on the next cycle returns the new data (memory behaviour, no bypass in arbiter).
- core_stall is purely combinational: high only when core_req=1 and aux is force-granted. The MEM stage holds its request stable while stalled.
- Requester changing addr/we while not granted is legal; only the values at the granted edge matter.
- Reset asserted mid-read: the pending rvalid is dropped; no rvalid after reset release until a new granted read.
- Request semantics: a requester holding req high after grant issues a new access each cycle. There is no implicit burst lock.

Test Plan:
- Reset: hold reset=0 with both req=1 -> core_gnt=aux_gnt=0, mem_wren=0, rvalids=0, starve_cnt=0. Release -> core_gnt=1 in same cycle.
- Core-only: write 0xDEADBEEF @0x012, then read @0x012 next cycle -> core_rvalid pulses 1 cycle with core_rdata=0xDEADBEEF; aux_rvalid stays 0.
- Starvation (STARVE_LIMIT=4): core_req and aux_req held high continuously -> starve_cnt 0,1,2,3,4. On the 5th cycle aux_gnt=1, core_stall=1, core_gnt=0. Next cycle starve_cnt=0 and core_gnt=1; the pattern repeats every 5 cycles.
- Interleaved reads: core read @0x001 (holds 0x11) on cycle N, aux-only read @0x002 (holds 0x22) on cycle N+1 -> core_rvalid at N+1 with 0x11, aux_rvalid at N+2 with 0x22, no overlap.
- Counter clear: aux_req high 2 cycles while losing (starve_cnt=2), aux_req low 1 cycle -> starve_cnt=0. No forced grant occurs before 4 further lost cycles.
- Async reset mid-read: core read granted, reset pulsed low before the next edge -> core_rvalid stays 0 through and after reset release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: fixed-priority core/aux arbiter for the single-port data memory with aux starvation guard
module dmem_arbiter #(
  parameter int XLEN         = 32,
  parameter int ADDR_W       = 9,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [XLEN-1:0]   core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [XLEN-1:0]   core_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [XLEN-1:0]   aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [XLEN-1:0]   aux_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [XLEN-1:0]   mem_data,
  output logic              mem_wren,
  input  logic [XLEN-1:0]   mem_q,
  output logic [3:0]        starve_cnt
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_AUX} owner_e;
  owner_e     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  logic       force_aux;
  // winner selection, memory mux and next-state for the counter and read owner
  always_comb begin
    force_aux   = core_req & aux_req & (starve_q == LIMIT);
    core_gnt    = reset & core_req & ~force_aux;
    aux_gnt     = reset & aux_req & (~core_req | force_aux);
    core_stall  = core_req & force_aux;
    mem_address = core_gnt ? core_addr : aux_gnt ? aux_addr : '0;
    mem_data    = core_gnt ? core_wdata : aux_gnt ? aux_wdata : '0;
    mem_wren    = (core_gnt & core_we) | (aux_gnt & aux_we);
    starve_d    = (~aux_req | aux_gnt) ? 4'd0 : (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
    owner_d     = (core_gnt & ~core_we) ? OWN_CORE : (aux_gnt & ~aux_we) ? OWN_AUX : OWN_NONE;
  end
  // starvation count and owner of the read data returning next cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_q <= 4'd0;
      owner_q  <= OWN_NONE;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end
  assign core_rvalid = owner_q == OWN_CORE;
  assign aux_rvalid  = owner_q == OWN_AUX;
  assign core_rdata  = mem_q;
  assign aux_rdata   = mem_q;
  assign starve_cnt  = starve_q;
endmodule
